rgbled_multi_driver: RTL and testbench

Next-generation WS2812-style serial LED driver. It drives CHANNELS independent LED strings in lockstep from one shared timing engine. Pixel data is fetched one LED at a time from an external pixel store over a read port, instead of a full frame-wide parallel bus. All bit timing is set by parameters, so the block retargets to any clock frequency or LED variant. It sits between the SPI/frame-store front end and the pad outputs.

---
 rtl/rgbled_pkg.sv | 23 ++
 rtl/rgbled_multi_driver_if.sv | 36 +++
 rtl/rgbled_bit_timer.sv | 45 ++++
 rtl/rgbled_multi_driver.sv | 170 +++++++++++++++++
 tb/tb_rgbled_multi_driver.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgbled_pkg.sv
// Shared types and defaults for the multi-string WS2812-style LED driver.
// Default timing targets a 10 MHz clock (100 ns per cycle).
package rgbled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    BIT,
    LATCH
  } state_t;

  localparam int DEF_T0H_CYCLES    = 4;
  localparam int DEF_T1H_CYCLES    = 8;
  localparam int DEF_TBIT_CYCLES   = 13;
  localparam int DEF_TRESET_CYCLES = 3000;

  // Bits needed for a counter that takes n distinct values (0..n-1), at least 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgbled_multi_driver_if.sv
// Control, pixel-store read port and LED outputs of rgbled_multi_driver.
// RGBLED_BLANK_EN adds the blank input sampled at frame start.
interface rgbled_multi_driver_if #(
  parameter int CHANNELS     = 4,
  parameter int BITS_PER_LED = 24,
  parameter int AW           = 4
);
  logic                             start;
  logic                             busy;
  logic                             done;
  logic                             pix_rd;
  logic [AW-1:0]                    pix_addr;
  logic [CHANNELS*BITS_PER_LED-1:0] pix_data;
  logic [CHANNELS-1:0]              led;
`ifdef RGBLED_BLANK_EN
  logic                             blank;

  modport master (
    input  start, blank, pix_data,
    output busy, done, pix_rd, pix_addr, led
  );
  modport slave (
    output start, blank, pix_data,
    input  busy, done, pix_rd, pix_addr, led
  );
`else
  modport master (
    input  start, pix_data,
    output busy, done, pix_rd, pix_addr, led
  );
  modport slave (
    output start, pix_data,
    input  busy, done, pix_rd, pix_addr, led
  );
`endif
endinterface

// File: rtl/rgbled_bit_timer.sv
// Shared bit-period phase counter and per-channel high-time compare.
module rgbled_bit_timer
  import rgbled_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int T0H_CYCLES  = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES  = DEF_T1H_CYCLES,
  parameter int TBIT_CYCLES = DEF_TBIT_CYCLES
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                run,
  input  logic [CHANNELS-1:0] bit_value,
  output logic [CHANNELS-1:0] led,
  output logic                bit_end
);

  localparam int PW = cnt_width(TBIT_CYCLES);
  localparam logic [PW-1:0] PHASE_LAST = PW'(TBIT_CYCLES - 1);
  localparam logic [PW-1:0] T0H_PH     = PW'(T0H_CYCLES);
  localparam logic [PW-1:0] T1H_PH     = PW'(T1H_CYCLES);

  logic [PW-1:0] phase;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase <= '0;
    end else if (!run || phase == PHASE_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign bit_end = run && (phase == PHASE_LAST);

  // led goes low combinationally with run, so an async reset blanks it at once
  always_comb begin
    led = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      led[c] = run && (phase < (bit_value[c] ? T1H_PH : T0H_PH));
    end
  end

endmodule

// File: rtl/rgbled_multi_driver.sv
// Drives CHANNELS WS2812-style strings in lockstep, fetching one LED per read.
// Optional RGBLED_BLANK_EN: frames started with blank=1 shift zeros and skip reads.
module rgbled_multi_driver
  import rgbled_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int LEDS          = 10,
  parameter int BITS_PER_LED  = 24,
  parameter int T0H_CYCLES    = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES    = DEF_T1H_CYCLES,
  parameter int TBIT_CYCLES   = DEF_TBIT_CYCLES,
  parameter int TRESET_CYCLES = DEF_TRESET_CYCLES,
  parameter int AW            = cnt_width(LEDS)
) (
  input logic                   clk,
  input logic                   nreset,
  rgbled_multi_driver_if.master bus
);

  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
        T1H_CYCLES < TBIT_CYCLES && TBIT_CYCLES >= 3)) begin : g_bad_timing
    $error("rgbled_multi_driver: illegal bit timing parameters");
  end

  localparam int BW = cnt_width(BITS_PER_LED);
  localparam int LW = cnt_width(TRESET_CYCLES);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_LED - 1);
  localparam logic [AW-1:0] LED_LAST   = AW'(LEDS - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(TRESET_CYCLES - 1);

  state_t                               state;
  logic [BW-1:0]                        bit_cnt;
  logic [AW-1:0]                        led_cnt;
  logic [LW-1:0]                        latch_cnt;
  logic [CHANNELS-1:0][BITS_PER_LED-1:0] shift;
  logic [CHANNELS-1:0][BITS_PER_LED-1:0] prefetch;
  logic                                 pf_pend;
  logic                                 blank_r;
  logic                                 blank_in;
  logic                                 busy;
  logic                                 done;
  logic                                 pix_rd;
  logic [AW-1:0]                        pix_addr;
  logic                                 run;
  logic                                 bit_end;
  logic [CHANNELS-1:0]                  msb;

`ifdef RGBLED_BLANK_EN
  assign blank_in = bus.blank;
`else
  assign blank_in = 1'b0;
`endif

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pix_rd   = pix_rd;
  assign bus.pix_addr = pix_addr;
  assign run          = (state == BIT);

  always_comb begin
    msb = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      msb[c] = shift[c][BITS_PER_LED-1];
    end
  end

  rgbled_bit_timer #(
    .CHANNELS   (CHANNELS),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .TBIT_CYCLES(TBIT_CYCLES)
  ) u_bit_timer (
    .clk      (clk),
    .nreset   (nreset),
    .run      (run),
    .bit_value(msb),
    .led      (bus.led),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_rd    <= 1'b0;
      pix_addr  <= '0;
      bit_cnt   <= '0;
      led_cnt   <= '0;
      latch_cnt <= '0;
      shift     <= '0;
      prefetch  <= '0;
      pf_pend   <= 1'b0;
      blank_r   <= 1'b0;
    end else begin
      pix_rd  <= 1'b0;
      done    <= 1'b0;
      // read data arrives the cycle after a prefetch strobe
      pf_pend <= pix_rd && (state == BIT);
      if (pf_pend) begin
        prefetch <= blank_r ? '0 : bus.pix_data;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            blank_r   <= blank_in;
            pix_rd    <= !blank_in;
            pix_addr  <= '0;
            bit_cnt   <= '0;
            led_cnt   <= '0;
            latch_cnt <= '0;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shift <= blank_r ? '0 : bus.pix_data;
          state <= BIT;
          if (LEDS > 1) begin
            pix_rd   <= !blank_r;
            pix_addr <= AW'(1);
          end
        end
        BIT: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (led_cnt == LED_LAST) begin
                state     <= LATCH;
                latch_cnt <= '0;
                if (TRESET_CYCLES == 1) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                end
              end else begin
                // next LED starts immediately; its successor is requested now
                shift   <= prefetch;
                led_cnt <= led_cnt + AW'(1);
                if (int'(led_cnt) + 2 < LEDS) begin
                  pix_rd   <= !blank_r;
                  pix_addr <= AW'(int'(led_cnt) + 2);
                end
              end
            end else begin
              for (int c = 0; c < CHANNELS; c++) begin
                shift[c] <= shift[c] << 1;
              end
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        LATCH: begin
          if (latch_cnt == LATCH_LAST) begin
            state <= IDLE;
          end else begin
            latch_cnt <= latch_cnt + LW'(1);
            if (int'(latch_cnt) + 2 == TRESET_CYCLES) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgbled_multi_driver.sv
// Scoreboard bench for rgbled_multi_driver (2 strings x 2 LEDs x 8 bits).
// Define RGBLED_BLANK_EN to also exercise the blank input.
module tb_rgbled_multi_driver;

  localparam int CH   = 2;
  localparam int LEDS = 2;
  localparam int B    = 8;
  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int TBIT = 6;
  localparam int TR   = 20;
  localparam int LAST_BIT_K = 2 + LEDS * B * TBIT;
  localparam int DONE_K     = LAST_BIT_K + TR;

  typedef struct packed {
    logic [CH-1:0] led;
    logic          busy;
    logic          done;
    logic          rd;
    logic [0:0]    addr;
  } exp_t;

  exp_t          sb[$];
  int            total;
  int            bad;
  logic          clk;
  logic          nreset;
  logic [CH*B-1:0] mem [LEDS];

  rgbled_multi_driver_if #(.CHANNELS(CH), .BITS_PER_LED(B), .AW(1)) bus ();

  rgbled_multi_driver #(
    .CHANNELS     (CH),
    .LEDS         (LEDS),
    .BITS_PER_LED (B),
    .T0H_CYCLES   (T0H),
    .T1H_CYCLES   (T1H),
    .TBIT_CYCLES  (TBIT),
    .TRESET_CYCLES(TR),
    .AW           (1)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel store: registered read, random junk when not read
  always @(posedge clk) begin
    if (bus.pix_rd === 1'b1) bus.pix_data <= mem[bus.pix_addr];
    else                     bus.pix_data <= 16'($urandom);
  end

  // Expected outputs for cycle k of a frame whose start was accepted at cycle 0
  function automatic exp_t model(input int k, input logic blank);
    exp_t e;
    int   j, n, b, p;
    logic bv;
    e = '0;
    e.busy = (k >= 1 && k < DONE_K);
    e.done = (k == DONE_K);
    if (!blank) begin
      if (k == 1) e.rd = 1'b1;
      for (int m = 0; m < LEDS - 1; m++) begin
        if (k == 3 + m * B * TBIT) begin
          e.rd   = 1'b1;
          e.addr = 1'(m + 1);
        end
      end
    end
    if (k >= 3 && k <= LAST_BIT_K) begin
      j = k - 3;
      n = j / (B * TBIT);
      b = (j / TBIT) % B;
      p = j % TBIT;
      for (int c = 0; c < CH; c++) begin
        bv = blank ? 1'b0 : mem[n][c*B + (B-1-b)];
        e.led[c] = (p < (bv ? T1H : T0H));
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [4:0] obs;
    nreset = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.led !== 2'b00)  begin bad++; $display("FAIL reset_led got=%b want=00", bus.led); end
    total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.pix_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b want=0", bus.pix_rd); end
    total++; if (bus.pix_addr !== 1'b0) begin bad++; $display("FAIL reset_addr got=%b want=0", bus.pix_addr); end
    nreset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      obs = {bus.led, bus.busy, bus.done, bus.pix_rd};
      total++;
      if (obs !== 5'b0) begin bad++; $display("FAIL idle i=%0d got=%b want=00000", i, obs); end
    end
  endtask

  task automatic test_frame();
    exp_t       e;
    logic [4:0] obs;
    int         rises[$];
    int         done_k;
    logic       prev;
    mem[0] = {8'h0F, 8'hA5};
    mem[1] = {8'h00, 8'hFF};
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= DONE_K; k++) sb.push_back(model(k, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    prev = 1'b0;
    done_k = -1;
    for (int k = 1; k <= DONE_K; k++) begin
      e = sb.pop_front();
      obs = {bus.led, bus.busy, bus.done, bus.pix_rd};
      total++;
      if (obs !== {e.led, e.busy, e.done, e.rd}) begin
        bad++; $display("FAIL frame k=%0d {led,busy,done,rd} got=%b want=%b", k, obs, {e.led, e.busy, e.done, e.rd});
      end
      if (e.rd) begin
        total++;
        if (bus.pix_addr !== e.addr) begin bad++; $display("FAIL frame_addr k=%0d got=%b want=%b", k, bus.pix_addr, e.addr); end
      end
      if (bus.led[0] === 1'b1 && !prev) rises.push_back(k);
      prev = bus.led[0];
      if (bus.done === 1'b1 && done_k < 0) done_k = k;
      @(negedge clk);
    end
    total++; if (done_k !== DONE_K) begin bad++; $display("FAIL done_cycle got=%0d want=%0d", done_k, DONE_K); end
    total++; if (rises.size() !== 16) begin bad++; $display("FAIL ch0_rises got=%0d want=16", rises.size()); end
    total++;
    if (rises.size() >= 9) begin
      if (rises[0] !== 3) begin bad++; $display("FAIL first_rise got=%0d want=3", rises[0]); end
      total++;
      if (rises[8] - rises[7] !== TBIT) begin
        bad++; $display("FAIL led_boundary_period got=%0d want=%0d", rises[8] - rises[7], TBIT);
      end
    end else begin
      bad++; $display("FAIL led_boundary too few rises got=%0d want=16", rises.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [4:0] obs;
    int         n;
    n = 2 * DONE_K + 4;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= DONE_K; k++) sb.push_back(model(k, 1'b0));
    sb.push_back(model(0, 1'b0));
    for (int k = 1; k <= DONE_K; k++) sb.push_back(model(k, 1'b0));
    for (int k = 0; k < 3; k++) sb.push_back(model(0, 1'b0));
    @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      e = sb.pop_front();
      obs = {bus.led, bus.busy, bus.done, bus.pix_rd};
      total++;
      if (obs !== {e.led, e.busy, e.done, e.rd}) begin
        bad++; $display("FAIL b2b i=%0d {led,busy,done,rd} got=%b want=%b", i, obs, {e.led, e.busy, e.done, e.rd});
      end
      if (e.rd) begin
        total++;
        if (bus.pix_addr !== e.addr) begin bad++; $display("FAIL b2b_addr i=%0d got=%b want=%b", i, bus.pix_addr, e.addr); end
      end
      if (i == DONE_K + 2)  bus.start = 1'b0;
      if (i == DONE_K + 30) bus.start = 1'b1;
      if (i == DONE_K + 31) bus.start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t       e;
    logic [4:0] obs;
    mem[0] = {8'h81, 8'h3C};
    mem[1] = {8'h5A, 8'h96};
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 52; k++) sb.push_back(model(k, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      e = sb.pop_front();
      obs = {bus.led, bus.busy, bus.done, bus.pix_rd};
      total++;
      if (obs !== {e.led, e.busy, e.done, e.rd}) begin
        bad++; $display("FAIL pre_reset k=%0d got=%b want=%b", k, obs, {e.led, e.busy, e.done, e.rd});
      end
      @(negedge clk);
    end
    e = model(53, 1'b0);
    total++;
    if (bus.led[0] !== e.led[0]) begin bad++; $display("FAIL mid_bit_led got=%b want=%b", bus.led[0], e.led[0]); end
    #2 nreset = 1'b0;
    #1;
    obs = {bus.led, bus.busy, bus.done, bus.pix_rd};
    total++; if (obs !== 5'b0) begin bad++; $display("FAIL async_reset got=%b want=00000", obs); end
    total++; if (bus.pix_addr !== 1'b0) begin bad++; $display("FAIL async_reset_addr got=%b want=0", bus.pix_addr); end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {bus.led, bus.busy, bus.done, bus.pix_rd};
      total++;
      if (obs !== 5'b0) begin bad++; $display("FAIL post_reset_idle i=%0d got=%b want=00000", i, obs); end
    end
    bus.start = 1'b1;
    for (int k = 1; k <= DONE_K; k++) sb.push_back(model(k, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= DONE_K; k++) begin
      e = sb.pop_front();
      obs = {bus.led, bus.busy, bus.done, bus.pix_rd};
      total++;
      if (obs !== {e.led, e.busy, e.done, e.rd}) begin
        bad++; $display("FAIL restart k=%0d got=%b want=%b", k, obs, {e.led, e.busy, e.done, e.rd});
      end
      if (e.rd) begin
        total++;
        if (bus.pix_addr !== e.addr) begin bad++; $display("FAIL restart_addr k=%0d got=%b want=%b", k, bus.pix_addr, e.addr); end
      end
      @(negedge clk);
    end
  endtask

`ifdef RGBLED_BLANK_EN
  task automatic test_blank();
    exp_t       e;
    logic [4:0] obs;
    int         reads;
    mem[0] = {8'hC3, 8'hFF};
    mem[1] = {8'h7E, 8'hAA};
    reads = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.blank = 1'b1;
    for (int k = 1; k <= DONE_K; k++) sb.push_back(model(k, 1'b1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.blank = 1'b0;
    for (int k = 1; k <= DONE_K; k++) begin
      e = sb.pop_front();
      obs = {bus.led, bus.busy, bus.done, bus.pix_rd};
      total++;
      if (obs !== {e.led, e.busy, e.done, e.rd}) begin
        bad++; $display("FAIL blank k=%0d got=%b want=%b", k, obs, {e.led, e.busy, e.done, e.rd});
      end
      if (bus.pix_rd === 1'b1) reads++;
      @(negedge clk);
    end
    total++; if (reads !== 0) begin bad++; $display("FAIL blank_reads got=%0d want=0", reads); end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    bus.start = 1'b0;
`ifdef RGBLED_BLANK_EN
    bus.blank = 1'b0;
`endif
    mem[0] = '0;
    mem[1] = '0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_reset_mid();
`ifdef RGBLED_BLANK_EN
    test_blank();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
